lcd_ctrl: RTL and testbench

- HD44780-compatible character-LCD timing controller, downstream of the pipeline's LSU LCD output.
- Accepts one command or data byte per valid/ready handshake and drives the LCD pins with correct setup, enable-pulse, hold and execution timing.
- Runs a power-up init sequence on its own, so firmware only writes bytes.

---
 rtl/lcd_pkg.sv | 33 +++
 rtl/lcd_if.sv | 14 +
 rtl/lcd_timer.sv | 37 +++
 rtl/lcd_ctrl.sv | 171 +++++++++++++++++
 tb/tb_lcd_ctrl.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/lcd_pkg.sv
// lcd_pkg: shared types and constants for the HD44780 character-LCD controller.
//   lcd_state_e  - controller state encoding
//   INIT_ROM     - power-up init command bytes, sent in order with RS=0
//   CMD_CLEAR/CMD_HOME - commands that need the long execution wait
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_PWRUP,
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD,
    ST_EXEC
  } lcd_state_e;

  localparam int unsigned INIT_LEN = 4;
  // 8-bit/2-line, display on, clear, entry mode increment
  localparam logic [7:0] INIT_ROM [INIT_LEN] = '{8'h38, 8'h0C, 8'h01, 8'h06};

  localparam logic [7:0] CMD_CLEAR = 8'h01;
  localparam logic [7:0] CMD_HOME  = 8'h02;

  // 0x03 is also return-home: DB0 is a don't-care for that instruction.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
    return !rs && (data == CMD_CLEAR || data == CMD_HOME ||
                   data == (CMD_HOME | CMD_CLEAR));
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd_if.sv
// lcd_if: byte request channel into the LCD controller (valid/ready).
//   req_valid - request present (master -> slave)
//   req_ready - controller can accept (slave -> master)
//   req_rs    - 0 = command, 1 = character data
//   req_data  - byte to send
interface lcd_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_rs;
  logic [7:0] req_data;

  modport master (output req_valid, output req_rs, output req_data, input  req_ready);
  modport slave  (input  req_valid, input  req_rs, input  req_data, output req_ready);
endinterface

// File: rtl/lcd_timer.sv
// lcd_timer: loadable down-counter used for every timed controller state.
//   clk_i, rst_ni - clock, asynchronous active-low reset (count -> RST_VAL)
//   load_i        - load value_i on this edge (has priority over counting)
//   value_i       - cycles-minus-one to spend in the state being entered
//   done_o        - count has reached zero; stays there until reloaded
module lcd_timer #(
  parameter int unsigned   W       = 8,
  parameter logic [W-1:0]  RST_VAL = '0
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] value_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = value_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= RST_VAL;
    else         cnt_q <= cnt_d;
  end

  // done_o looks only at the stored count, so the FSM can decide a
  // transition and issue the reload on the same edge without a loop.
  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/lcd_ctrl.sv
// lcd_ctrl: HD44780-compatible character-LCD timing controller.
//   clk_i, rst_ni - clock, asynchronous active-low reset
//   req           - lcd_if.slave byte channel (valid/ready, rs, data)
//   busy_o        - inverse of req_ready
//   init_done_o   - power-up init sequence finished (sticky)
//   lcd_on_o      - LCD power enable
//   lcd_en_o, lcd_rs_o, lcd_rw_o, lcd_data_o - LCD pins (registered, RW fixed 0)
module lcd_ctrl
  import lcd_pkg::*;
#(
  parameter int unsigned T_SETUP = 2,
  parameter int unsigned T_EN    = 12,
  parameter int unsigned T_HOLD  = 2,
  parameter int unsigned T_EXEC  = 2000,
  parameter int unsigned T_LONG  = 82000,
  parameter int unsigned T_PWRUP = 750000,
  parameter bit          INIT_EN = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  lcd_if.slave       req,
  output logic       busy_o,
  output logic       init_done_o,
  output logic       lcd_on_o,
  output logic       lcd_en_o,
  output logic       lcd_rs_o,
  output logic       lcd_rw_o,
  output logic [7:0] lcd_data_o
);

  localparam int unsigned T_MAX = max_u(max_u(max_u(T_SETUP, T_EN), max_u(T_HOLD, T_EXEC)),
                                        max_u(T_LONG, T_PWRUP));
  localparam int unsigned CNT_W = $clog2(T_MAX) + 1;
  localparam int unsigned IDX_W = $clog2(INIT_LEN);

  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [IDX_W-1:0] idx_t;

  // Timer values are cycles-minus-one: the entry edge already counts.
  localparam cnt_t LD_SETUP = cnt_t'(T_SETUP - 1);
  localparam cnt_t LD_EN    = cnt_t'(T_EN - 1);
  localparam cnt_t LD_HOLD  = cnt_t'(T_HOLD - 1);
  localparam cnt_t LD_EXEC  = cnt_t'(T_EXEC - 1);
  localparam cnt_t LD_LONG  = cnt_t'(T_LONG - 1);
  localparam cnt_t LD_PWRUP = INIT_EN ? cnt_t'(T_PWRUP - 1) : '0;

  localparam lcd_state_e RST_STATE = INIT_EN ? ST_PWRUP : ST_IDLE;

  lcd_state_e state_q, state_d;
  logic       en_q, en_d;
  logic       rs_q, rs_d;
  logic [7:0] data_q, data_d;
  logic       on_q, on_d;
  logic       ready_q, ready_d;
  logic       init_done_q, init_done_d;
  idx_t       idx_q, idx_d;

  logic       t_load;
  cnt_t       t_value;
  logic       t_done;
  logic       accept;

  lcd_timer #(
    .W       (CNT_W),
    .RST_VAL (LD_PWRUP)
  ) u_timer (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .load_i  (t_load),
    .value_i (t_value),
    .done_o  (t_done)
  );

  assign accept = req.req_valid && ready_q;

  always_comb begin
    state_d     = state_q;
    en_d        = en_q;
    rs_d        = rs_q;
    data_d      = data_q;
    on_d        = 1'b1;
    idx_d       = idx_q;
    init_done_d = init_done_q | !INIT_EN;
    t_load      = 1'b0;
    t_value     = '0;

    unique case (state_q)
      ST_PWRUP: if (t_done) begin
        state_d = ST_SETUP;
        rs_d    = 1'b0;
        idx_d   = '0;
        data_d  = INIT_ROM[0];
        t_load  = 1'b1;
        t_value = LD_SETUP;
      end
      ST_IDLE: if (accept) begin
        state_d = ST_SETUP;
        rs_d    = req.req_rs;
        data_d  = req.req_data;
        t_load  = 1'b1;
        t_value = LD_SETUP;
      end
      ST_SETUP: if (t_done) begin
        state_d = ST_PULSE;
        en_d    = 1'b1;
        t_load  = 1'b1;
        t_value = LD_EN;
      end
      ST_PULSE: if (t_done) begin
        state_d = ST_HOLD;
        en_d    = 1'b0;
        t_load  = 1'b1;
        t_value = LD_HOLD;
      end
      ST_HOLD: if (t_done) begin
        state_d = ST_EXEC;
        t_load  = 1'b1;
        t_value = is_long_cmd(rs_q, data_q) ? LD_LONG : LD_EXEC;
      end
      ST_EXEC: if (t_done) begin
        // During init, EXEC chains straight into the next ROM command.
        if (!init_done_q && idx_q != idx_t'(INIT_LEN - 1)) begin
          state_d = ST_SETUP;
          idx_d   = idx_q + idx_t'(1);
          rs_d    = 1'b0;
          data_d  = INIT_ROM[idx_d];
          t_load  = 1'b1;
          t_value = LD_SETUP;
        end else begin
          state_d     = ST_IDLE;
          init_done_d = 1'b1;
        end
      end
      default: state_d = RST_STATE;
    endcase

    ready_d = (state_d == ST_IDLE) && init_done_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= RST_STATE;
      en_q        <= 1'b0;
      rs_q        <= 1'b0;
      data_q      <= '0;
      on_q        <= 1'b0;
      ready_q     <= 1'b0;
      init_done_q <= 1'b0;
      idx_q       <= '0;
    end else begin
      state_q     <= state_d;
      en_q        <= en_d;
      rs_q        <= rs_d;
      data_q      <= data_d;
      on_q        <= on_d;
      ready_q     <= ready_d;
      init_done_q <= init_done_d;
      idx_q       <= idx_d;
    end
  end

  assign req.req_ready = ready_q;
  assign busy_o        = !ready_q;
  assign init_done_o   = init_done_q;
  assign lcd_on_o      = on_q;
  assign lcd_en_o      = en_q;
  assign lcd_rs_o      = rs_q;
  assign lcd_rw_o      = 1'b0;
  assign lcd_data_o    = data_q;

endmodule

// File: tb/tb_lcd_ctrl.sv
// tb_lcd_ctrl: self-checking bench for lcd_ctrl with short sim timings.
module tb_lcd_ctrl;

  localparam int T_SETUP = 1;
  localparam int T_EN    = 2;
  localparam int T_HOLD  = 1;
  localparam int T_EXEC  = 4;
  localparam int T_LONG  = 10;
  localparam int T_PWRUP = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       busy, init_done, lcd_on, lcd_en, lcd_rs, lcd_rw;
  logic [7:0] lcd_data;

  int n_cmp = 0;
  int n_err = 0;

  lcd_if bus ();

  lcd_ctrl #(
    .T_SETUP (T_SETUP),
    .T_EN    (T_EN),
    .T_HOLD  (T_HOLD),
    .T_EXEC  (T_EXEC),
    .T_LONG  (T_LONG),
    .T_PWRUP (T_PWRUP),
    .INIT_EN (1'b1)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req         (bus),
    .busy_o      (busy),
    .init_done_o (init_done),
    .lcd_on_o    (lcd_on),
    .lcd_en_o    (lcd_en),
    .lcd_rs_o    (lcd_rs),
    .lcd_rw_o    (lcd_rw),
    .lcd_data_o  (lcd_data)
  );

  always #5 clk = ~clk;

  initial begin
    #200us;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  // Reference: total cycles from the accepting edge until ready returns.
  function automatic int xfer_len(input logic rs, input logic [7:0] d);
    return T_SETUP + T_EN + T_HOLD + ((!rs && d >= 8'h01 && d <= 8'h03) ? T_LONG : T_EXEC);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for ready, presents one request, returns right after the accept edge.
  task automatic send(input logic rs, input logic [7:0] d, input bit hold, output bit ok);
    int n = 0;
    while (bus.req_ready !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    ok = (bus.req_ready === 1'b1);
    bus.req_valid = 1'b1;
    bus.req_rs    = rs;
    bus.req_data  = d;
    tick();
    if (!hold) begin
      bus.req_valid = 1'b0;
      bus.req_rs    = 1'($urandom_range(0, 1));
      bus.req_data  = 8'($urandom_range(0, 255));
    end
  endtask

  // Measures one transfer starting at k=0 (just after the accept edge); no judging here.
  task automatic observe(output int rise, output int width, output int lat,
                         output logic [7:0] pd, output logic prs, output bit stable);
    rise = -1; width = 0; lat = -1; pd = lcd_data; prs = lcd_rs; stable = 1'b1;
    for (int k = 0; k <= 200; k++) begin
      if (k > 0) tick();
      if (lcd_data !== pd || lcd_rs !== prs) stable = 1'b0;
      if (lcd_en === 1'b1) begin
        if (rise < 0) rise = k;
        width++;
      end
      if (bus.req_ready === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  // Called with reset just released and no clock edge since.
  task automatic test_init_sequence(input string tag);
    logic [7:0] cmds [4];
    int         s [5];
    logic [7:0] exp_d;
    logic       exp_en, exp_rdy;
    cmds = '{8'h38, 8'h0C, 8'h01, 8'h06};
    s[0] = T_PWRUP;
    for (int i = 0; i < 4; i++) s[i+1] = s[i] + xfer_len(1'b0, cmds[i]);
    for (int k = 1; k <= s[4] + 2; k++) begin
      tick();
      exp_en = 1'b0;
      exp_d  = 8'h00;
      for (int i = 0; i < 4; i++) begin
        if (k >= s[i]) exp_d = cmds[i];
        if (k >= s[i] + T_SETUP && k < s[i] + T_SETUP + T_EN) exp_en = 1'b1;
      end
      exp_rdy = (k >= s[4]);
      n_cmp++;
      if (lcd_en !== exp_en) begin n_err++; $display("FAIL %s_en k=%0d: got %b want %b", tag, k, lcd_en, exp_en); end
      n_cmp++;
      if (lcd_data !== exp_d || lcd_rs !== 1'b0) begin
        n_err++; $display("FAIL %s_data k=%0d: got rs=%b %h want rs=0 %h", tag, k, lcd_rs, lcd_data, exp_d);
      end
      n_cmp++;
      if (bus.req_ready !== exp_rdy || busy !== !exp_rdy || init_done !== exp_rdy) begin
        n_err++; $display("FAIL %s_ready k=%0d: got rdy=%b busy=%b done=%b want rdy=done=%b", tag, k, bus.req_ready, busy, init_done, exp_rdy);
      end
      n_cmp++;
      if (lcd_on !== 1'b1 || lcd_rw !== 1'b0) begin n_err++; $display("FAIL %s_on k=%0d: got on=%b rw=%b want 1 0", tag, k, lcd_on, lcd_rw); end
    end
  endtask

  task automatic test_reset();
    logic [14:0] got;
    rst_n = 1'b0;
    bus.req_valid = 1'b0; bus.req_rs = 1'b0; bus.req_data = 8'h00;
    repeat (3) tick();
    got = {lcd_en, lcd_rs, lcd_rw, lcd_on, bus.req_ready, busy, init_done, lcd_data};
    n_cmp++;
    if (got !== 15'b000_0010_00000000) begin n_err++; $display("FAIL reset_vals: got %b want %b", got, 15'b000_0010_00000000); end
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (lcd_on !== 1'b0) begin n_err++; $display("FAIL on_before_edge: got %b want 0", lcd_on); end
    test_init_sequence("init");
  endtask

  task automatic test_data_write();
    bit ok; int rise, width, lat; logic [7:0] pd; logic prs; bit stable;
    send(1'b1, 8'h41, 1'b0, ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL wr_ready_wait: got timeout want ready"); end
    n_cmp++;
    if (lcd_rs !== 1'b1 || lcd_data !== 8'h41 || bus.req_ready !== 1'b0 || lcd_en !== 1'b0) begin
      n_err++; $display("FAIL wr_latch: got rs=%b d=%h rdy=%b en=%b want 1 41 0 0", lcd_rs, lcd_data, bus.req_ready, lcd_en);
    end
    observe(rise, width, lat, pd, prs, stable);
    n_cmp++;
    if (rise !== T_SETUP || width !== T_EN) begin n_err++; $display("FAIL wr_pulse: got rise=%0d w=%0d want %0d %0d", rise, width, T_SETUP, T_EN); end
    n_cmp++;
    if (lat !== 8 || !stable) begin n_err++; $display("FAIL wr_lat: got %0d stable=%0b want 8 1", lat, stable); end
  endtask

  task automatic test_long_cmd();
    bit ok; int rise, width, lat; logic [7:0] pd; logic prs; bit stable;
    logic       t_rs [5];
    logic [7:0] t_d  [5];
    int         t_lat [5];
    t_rs = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    t_d  = '{8'h01, 8'h01, 8'h02, 8'h03, 8'h04};
    t_lat = '{14, 8, 14, 14, 8};
    for (int i = 0; i < 5; i++) begin
      send(t_rs[i], t_d[i], 1'b0, ok);
      observe(rise, width, lat, pd, prs, stable);
      n_cmp++;
      if (!ok || lat !== t_lat[i] || width !== T_EN || pd !== t_d[i] || prs !== t_rs[i]) begin
        n_err++; $display("FAIL long_%0d: got ok=%0b lat=%0d w=%0d rs=%b d=%h want lat=%0d rs=%b d=%h", i, ok, lat, width, prs, pd, t_lat[i], t_rs[i], t_d[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit ok; int rise, width, lat; logic [7:0] pd; logic prs; bit stable;
    send(1'b1, 8'h48, 1'b1, ok);
    bus.req_data = 8'h49;
    observe(rise, width, lat, pd, prs, stable);
    n_cmp++;
    if (!ok || pd !== 8'h48 || !stable || lat !== 8 || width !== T_EN) begin
      n_err++; $display("FAIL b2b_first: got d=%h stable=%0b lat=%0d w=%0d want 48 1 8 %0d", pd, stable, lat, width, T_EN);
    end
    tick();
    bus.req_valid = 1'b0;
    n_cmp++;
    if (lcd_data !== 8'h49 || bus.req_ready !== 1'b0) begin
      n_err++; $display("FAIL b2b_accept: got d=%h rdy=%b want 49 0", lcd_data, bus.req_ready);
    end
    observe(rise, width, lat, pd, prs, stable);
    n_cmp++;
    if (lat !== 8 || pd !== 8'h49 || rise !== T_SETUP) begin
      n_err++; $display("FAIL b2b_second: got lat=%0d d=%h rise=%0d want 8 49 %0d", lat, pd, rise, T_SETUP);
    end
  endtask

  task automatic test_not_ready();
    bit ok; int n; bit en_seen;
    send(1'b0, 8'h0C, 1'b0, ok);
    repeat (T_SETUP + T_EN + T_HOLD) tick();
    bus.req_valid = 1'b1; bus.req_rs = 1'b1; bus.req_data = 8'h55;
    repeat (2) tick();
    bus.req_valid = 1'b0;
    n = 0;
    while (bus.req_ready !== 1'b1 && n < 50) begin tick(); n++; end
    n_cmp++;
    if (bus.req_ready !== 1'b1) begin n_err++; $display("FAIL nr_ready_wait: got timeout want ready"); end
    en_seen = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (lcd_en !== 1'b0) en_seen = 1'b1;
      n_cmp++;
      if (bus.req_ready !== 1'b1 || lcd_data !== 8'h0C || lcd_rs !== 1'b0) begin
        n_err++; $display("FAIL nr_idle k=%0d: got rdy=%b rs=%b d=%h want 1 0 0c", k, bus.req_ready, lcd_rs, lcd_data);
      end
    end
    n_cmp++;
    if (en_seen) begin n_err++; $display("FAIL nr_no_pulse: got en pulse want none"); end
  endtask

  task automatic test_random();
    bit ok; int rise, width, lat; logic [7:0] pd; logic prs; bit stable;
    logic rs; logic [7:0] d;
    for (int i = 0; i < 16; i++) begin
      repeat ($urandom_range(0, 2)) tick();
      rs = 1'($urandom_range(0, 1));
      d  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 3)) : 8'($urandom_range(0, 255));
      send(rs, d, 1'b0, ok);
      observe(rise, width, lat, pd, prs, stable);
      n_cmp++;
      if (!ok || pd !== d || prs !== rs || !stable) begin
        n_err++; $display("FAIL rnd_byte_%0d: got rs=%b d=%h stable=%0b want rs=%b d=%h", i, prs, pd, stable, rs, d);
      end
      n_cmp++;
      if (rise !== T_SETUP || width !== T_EN || lat !== xfer_len(rs, d)) begin
        n_err++; $display("FAIL rnd_time_%0d: got rise=%0d w=%0d lat=%0d want %0d %0d %0d", i, rise, width, lat, T_SETUP, T_EN, xfer_len(rs, d));
      end
    end
  endtask

  task automatic test_reset_mid_pulse();
    bit ok; int n; logic [14:0] got;
    send(1'b1, 8'h5A, 1'b0, ok);
    n = 0;
    while (lcd_en !== 1'b1 && n < 20) begin tick(); n++; end
    n_cmp++;
    if (lcd_en !== 1'b1) begin n_err++; $display("FAIL mid_en_wait: got timeout want en=1"); end
    #2 rst_n = 1'b0;
    #1;
    got = {lcd_en, lcd_rs, lcd_rw, lcd_on, bus.req_ready, busy, init_done, lcd_data};
    n_cmp++;
    if (got !== 15'b000_0010_00000000) begin n_err++; $display("FAIL mid_reset_vals: got %b want %b", got, 15'b000_0010_00000000); end
    repeat (2) tick();
    rst_n = 1'b1;
    test_init_sequence("reinit");
  endtask

  initial begin
    test_reset();
    test_data_write();
    test_long_cmd();
    test_back_to_back();
    test_not_ready();
    test_random();
    test_reset_mid_pulse();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
